// File: rtl/js_stack_cpu.sv
// Single-issue stack machine: one 48-bit bytecode instruction per clock, fetched from the hatch port,
// operating on a 2048 x 32-bit operand stack that grows upward (SP names the next free entry).
module js_stack_cpu #(
  parameter  int INSN_BYTES  = 6,
  parameter  int STACK_DEPTH = 2048,
  localparam int SP_W        = $clog2(STACK_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [47:0]     hatch_instruction,
  input  logic [SP_W-1:0] st__saved_sp_3a,
  output logic [31:0]     hatch_address,
  output logic [SP_W-1:0] st__sp_2a
);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_PUSH  = 8'h01;
  localparam logic [7:0] OP_POP   = 8'h02;
  localparam logic [7:0] OP_DUP   = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h04;
  localparam logic [7:0] OP_SUB   = 8'h05;
  localparam logic [7:0] OP_AND   = 8'h06;
  localparam logic [7:0] OP_OR    = 8'h07;
  localparam logic [7:0] OP_XOR   = 8'h08;
  localparam logic [7:0] OP_JMP   = 8'h09;
  localparam logic [7:0] OP_JZ    = 8'h0A;
  localparam logic [7:0] OP_SETSP = 8'h0B;
  localparam logic [7:0] OP_HALT  = 8'h0C;

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  state_t          state_reg, state_next;
  logic [31:0]     pc_reg, pc_next;
  logic [SP_W-1:0] sp_reg, sp_next;

  logic [31:0]     mem [STACK_DEPTH];
  logic            wr_en;
  logic [SP_W-1:0] wr_addr;
  logic [31:0]     wr_data;

  logic [7:0]      opcode;
  logic [31:0]     imm;
  logic [SP_W-1:0] addr_a, addr_b;
  logic [31:0]     top_a, top_b;
  logic            unused_bits;

  assign opcode      = hatch_instruction[47:40];
  assign imm         = hatch_instruction[31:0];
  assign unused_bits = ^hatch_instruction[39:32];

  // Operands are read combinationally so every opcode completes in its own cycle,
  // including right after SETSP moves SP somewhere arbitrary.
  assign addr_a = sp_reg - SP_W'(1);
  assign addr_b = sp_reg - SP_W'(2);
  assign top_a  = mem[addr_a];
  assign top_b  = mem[addr_b];

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_reg <= S_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == S_RUN && opcode == OP_HALT) begin
      state_next = S_HALT;
    end
  end

  always_comb begin
    pc_next = pc_reg;
    sp_next = sp_reg;
    wr_en   = 1'b0;
    wr_addr = sp_reg;
    wr_data = imm;
    if (state_reg == S_RUN) begin
      pc_next = pc_reg + 32'(INSN_BYTES);
      case (opcode)
        OP_NOP: ;
        OP_PUSH: begin
          wr_en   = 1'b1;
          sp_next = sp_reg + SP_W'(1);
        end
        OP_POP: sp_next = addr_a;
        OP_DUP: begin
          wr_en   = 1'b1;
          wr_data = top_a;
          sp_next = sp_reg + SP_W'(1);
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          wr_en   = 1'b1;
          wr_addr = addr_b;
          sp_next = addr_a;
          case (opcode)
            OP_ADD:  wr_data = top_b + top_a;
            OP_SUB:  wr_data = top_b - top_a;
            OP_AND:  wr_data = top_b & top_a;
            OP_OR:   wr_data = top_b | top_a;
            default: wr_data = top_b ^ top_a;
          endcase
        end
        OP_JMP: pc_next = imm;
        OP_JZ: begin
          sp_next = addr_a;
          if (top_a == 32'd0) begin
            pc_next = imm;
          end
        end
        OP_SETSP: sp_next = st__saved_sp_3a;
        OP_HALT:  pc_next = pc_reg;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      pc_reg <= 32'd0;
      sp_reg <= '0;
    end else begin
      pc_reg <= pc_next;
      sp_reg <= sp_next;
    end
  end

  // Stack contents survive reset; writes are only suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (wr_en && !rst_b) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign hatch_address = pc_reg;
  assign st__sp_2a     = sp_reg;

endmodule

// File: tb/tb_js_stack_cpu.sv
// Directed bench for js_stack_cpu: per-cycle expected PC/SP go into a scoreboard queue and are
// compared after each edge; stack data is checked indirectly through JZ branch outcomes.
module tb_js_stack_cpu;

  logic        clk;
  logic        rst_b;
  logic [47:0] hatch_instruction;
  logic [10:0] st__saved_sp_3a;
  logic [31:0] hatch_address;
  logic [10:0] st__sp_2a;

  logic [47:0] imem [512];

  typedef struct {
    logic [31:0] addr;
    logic [10:0] sp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  js_stack_cpu dut (
    .clk               (clk),
    .rst_b             (rst_b),
    .hatch_instruction (hatch_instruction),
    .st__saved_sp_3a   (st__saved_sp_3a),
    .hatch_address     (hatch_address),
    .st__sp_2a         (st__sp_2a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign hatch_instruction = (hatch_address < 32'd512) ? imem[hatch_address[8:0]] : 48'd0;

  task automatic put(input int addr, input logic [7:0] op, input logic [31:0] imm);
    imem[addr] = {op, 8'hA5, imm};
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 512; i++) imem[i] = 48'd0;
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (hatch_address === e.addr) else begin
      failures++;
      $error("FAIL %s addr: observed=%0d expected=%0d", e.tag, hatch_address, e.addr);
    end
    checks++;
    assert (st__sp_2a === e.sp) else begin
      failures++;
      $error("FAIL %s sp: observed=0x%0h expected=0x%0h", e.tag, st__sp_2a, e.sp);
    end
    $display("step %-10s addr=%0d sp=0x%0h", e.tag, hatch_address, st__sp_2a);
  endtask

  task automatic step(input logic [31:0] addr, input logic [10:0] sp, input string tag);
    sb.push_back('{addr, sp, tag});
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    sb.push_back('{32'd0, 11'd0, "rst_async"});
    check_out();
    @(posedge clk);
    #1;
    sb.push_back('{32'd0, 11'd0, "rst_hold"});
    check_out();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_b           = 1'b0;
    st__saved_sp_3a = 11'd0;
    clear_prog();

    // NOP, NOP, HALT
    hold_reset();
    put(0, 8'h00, 0); put(6, 8'h00, 0); put(12, 8'h0C, 0);
    release_reset();
    step(6, 0, "nop1"); step(12, 0, "nop2"); step(12, 0, "halt");
    step(12, 0, "halted1"); step(12, 0, "halted2");

    // SUB ordering B-A, DUP value, and the value left below it
    hold_reset();
    clear_prog();
    put(0, 8'h01, 5); put(6, 8'h01, 3); put(12, 8'h05, 0); put(18, 8'h03, 0);
    put(24, 8'h01, 2); put(30, 8'h05, 0); put(36, 8'h0A, 96); put(42, 8'h0C, 0);
    put(96, 8'h01, 2); put(102, 8'h05, 0); put(108, 8'h0A, 150); put(114, 8'h0C, 0);
    put(150, 8'h0C, 0);
    release_reset();
    step(6, 1, "push5"); step(12, 2, "push3"); step(18, 1, "sub");
    step(24, 2, "dup"); step(30, 3, "push2"); step(36, 2, "sub0");
    step(96, 1, "jz_dup"); step(102, 2, "push2b"); step(108, 1, "sub1");
    step(150, 0, "jz_low"); step(150, 0, "halt");

    // ADD wrap, XOR, AND, OR verified through JZ
    hold_reset();
    clear_prog();
    put(0, 8'h01, 32'hFFFF_FFFF); put(6, 8'h01, 1); put(12, 8'h04, 0); put(18, 8'h0A, 48);
    put(48, 8'h01, 32'hF0F0); put(54, 8'h01, 32'hFF00); put(60, 8'h08, 0);
    put(66, 8'h01, 32'h0FF0); put(72, 8'h08, 0); put(78, 8'h0A, 120);
    put(120, 8'h01, 32'hF0F0); put(126, 8'h01, 32'hFF00); put(132, 8'h06, 0);
    put(138, 8'h01, 32'hF000); put(144, 8'h08, 0); put(150, 8'h0A, 200);
    put(200, 8'h01, 32'hF0F0); put(206, 8'h01, 32'h0F00); put(212, 8'h07, 0);
    put(218, 8'h01, 32'hFFF0); put(224, 8'h08, 0); put(230, 8'h0A, 300);
    put(300, 8'h0C, 0);
    release_reset();
    step(6, 1, "pushmax"); step(12, 2, "push1"); step(18, 1, "add_wrap"); step(48, 0, "jz_add");
    step(54, 1, "x_push"); step(60, 2, "x_push"); step(66, 1, "xor"); step(72, 2, "x_push");
    step(78, 1, "xor0"); step(120, 0, "jz_xor");
    step(126, 1, "a_push"); step(132, 2, "a_push"); step(138, 1, "and"); step(144, 2, "a_push");
    step(150, 1, "and_x"); step(200, 0, "jz_and");
    step(206, 1, "o_push"); step(212, 2, "o_push"); step(218, 1, "or"); step(224, 2, "o_push");
    step(230, 1, "or_x"); step(300, 0, "jz_or"); step(300, 0, "halt");

    // JZ taken and not taken
    hold_reset();
    clear_prog();
    put(0, 8'h01, 0); put(6, 8'h0A, 32'h18); put(24, 8'h01, 7); put(30, 8'h0A, 96);
    put(36, 8'h0C, 0);
    release_reset();
    step(6, 1, "push0"); step(24, 0, "jz_taken"); step(30, 1, "push7");
    step(36, 0, "jz_fall"); step(36, 0, "halt");

    // SETSP, POP wrap, unknown opcode, push wrap, JMP, halt freeze
    hold_reset();
    clear_prog();
    put(0, 8'h0B, 0); put(6, 8'h0B, 0); put(12, 8'h02, 0); put(18, 8'hFF, 0);
    put(24, 8'h01, 1); put(30, 8'h09, 96); put(96, 8'h0C, 0);
    st__saved_sp_3a = 11'h123;
    release_reset();
    step(6, 11'h123, "setsp");
    st__saved_sp_3a = 11'h000;
    step(12, 0, "setsp0"); step(18, 11'h7FF, "pop_wrap"); step(24, 11'h7FF, "bad_op");
    step(30, 0, "push_wrap"); step(96, 0, "jmp");
    st__saved_sp_3a = 11'h055;
    step(96, 0, "halt"); step(96, 0, "frozen1"); step(96, 0, "frozen2");

    // Asynchronous reset in the middle of a running loop
    hold_reset();
    clear_prog();
    put(0, 8'h01, 1); put(6, 8'h09, 0);
    release_reset();
    step(6, 1, "loop_push"); step(0, 1, "loop_jmp"); step(6, 2, "loop_push"); step(0, 2, "loop_jmp");
    #2;
    rst_b = 1'b1;
    #1;
    sb.push_back('{32'd0, 11'd0, "mid_rst"});
    check_out();
    @(posedge clk);
    #1;
    sb.push_back('{32'd0, 11'd0, "mid_hold"});
    check_out();
    release_reset();
    step(6, 1, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
